// File: rtl/ipgen_memory_arbiter.sv
// ipgen_memory_arbiter: merges NUM_CH burst master ports onto one slave port.
// Independent write and read paths, each granting one channel per burst and
// holding it until the last data beat. Round-robin by default; define
// IPGEN_MEMORY_ARBITER_FIXED_PRIORITY_EN for fixed (lowest index wins) priority.
module ipgen_memory_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int GW        = $clog2(NUM_CH)
) (
  input  logic                           CLK,
  input  logic                           RST,
  // upstream write address
  input  logic [NUM_CH-1:0]              m_awvalid,
  output logic [NUM_CH-1:0]              m_awready,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   m_awaddr,
  input  logic [NUM_CH*8-1:0]            m_awlen,
  // upstream write data
  input  logic [NUM_CH*DATA_WIDTH-1:0]   m_wdata,
  input  logic [NUM_CH*DATA_WIDTH/8-1:0] m_wstrb,
  input  logic [NUM_CH-1:0]              m_wlast,
  input  logic [NUM_CH-1:0]              m_wvalid,
  output logic [NUM_CH-1:0]              m_wready,
  // upstream read address
  input  logic [NUM_CH-1:0]              m_arvalid,
  output logic [NUM_CH-1:0]              m_arready,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   m_araddr,
  input  logic [NUM_CH*8-1:0]            m_arlen,
  // upstream read data (payload broadcast, valid per channel)
  output logic [DATA_WIDTH-1:0]          m_rdata,
  output logic                           m_rlast,
  output logic [NUM_CH-1:0]              m_rvalid,
  input  logic [NUM_CH-1:0]              m_rready,
  // downstream write address
  output logic                           s_awvalid,
  output logic [ADDR_WIDTH-1:0]          s_awaddr,
  output logic [7:0]                     s_awlen,
  input  logic                           s_awready,
  // downstream write data
  output logic [DATA_WIDTH-1:0]          s_wdata,
  output logic [DATA_WIDTH/8-1:0]        s_wstrb,
  output logic                           s_wlast,
  output logic                           s_wvalid,
  input  logic                           s_wready,
  // downstream read address
  output logic                           s_arvalid,
  output logic [ADDR_WIDTH-1:0]          s_araddr,
  output logic [7:0]                     s_arlen,
  input  logic                           s_arready,
  // downstream read data
  input  logic [DATA_WIDTH-1:0]          s_rdata,
  input  logic                           s_rlast,
  input  logic                           s_rvalid,
  output logic                           s_rready,
  // status
  output logic [GW-1:0]                  wr_grant,
  output logic [GW-1:0]                  rd_grant,
  output logic                           wr_busy,
  output logic                           rd_busy
);

  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA} wr_st_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_st_t;

  wr_st_t        r_wr_st, w_wr_st_nxt;
  rd_st_t        r_rd_st, w_rd_st_nxt;
  logic [GW-1:0] r_wgnt, w_wgnt_nxt, w_wr_pick;
  logic [GW-1:0] r_rgnt, w_rgnt_nxt, w_rd_pick;

  // index after g, wrapping at NUM_CH (NUM_CH need not be a power of two)
  function automatic logic [GW-1:0] f_next(input logic [GW-1:0] g);
    return (g == GW'(NUM_CH - 1)) ? '0 : g + GW'(1);
  endfunction

`ifdef IPGEN_MEMORY_ARBITER_FIXED_PRIORITY_EN
  // lowest requesting index wins
  function automatic logic [GW-1:0] f_pick(input logic [NUM_CH-1:0] req);
    logic [GW-1:0] sel;
    sel = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (req[k]) sel = GW'(k);
    return sel;
  endfunction

  assign w_wr_pick = f_pick(m_awvalid);
  assign w_rd_pick = f_pick(m_arvalid);
`else
  logic [GW-1:0] r_wr_ptr, w_wr_ptr_nxt;
  logic [GW-1:0] r_rd_ptr, w_rd_ptr_nxt;

  // first requester at or after ptr, wrapping through 0
  function automatic logic [GW-1:0] f_pick(input logic [NUM_CH-1:0] req,
                                           input logic [GW-1:0]     ptr);
    logic [GW-1:0] sel;
    logic          found;
    int            idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && req[idx]) begin
        sel   = GW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign w_wr_pick = f_pick(m_awvalid, r_wr_ptr);
  assign w_rd_pick = f_pick(m_arvalid, r_rd_ptr);

  // round-robin pointers, advanced only when a burst completes
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
    end
  end
`endif

  // state and grant registers for both paths
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_st <= W_IDLE;
      r_rd_st <= R_IDLE;
      r_wgnt  <= '0;
      r_rgnt  <= '0;
    end else begin
      r_wr_st <= w_wr_st_nxt;
      r_rd_st <= w_rd_st_nxt;
      r_wgnt  <= w_wgnt_nxt;
      r_rgnt  <= w_rgnt_nxt;
    end
  end

  assign wr_grant = r_wgnt;
  assign rd_grant = r_rgnt;
  assign wr_busy  = (r_wr_st != W_IDLE);
  assign rd_busy  = (r_rd_st != R_IDLE);

  // write path: arbitrate in IDLE, pass granted channel through otherwise
  always_comb begin
    w_wr_st_nxt = r_wr_st;
    w_wgnt_nxt  = r_wgnt;
`ifndef IPGEN_MEMORY_ARBITER_FIXED_PRIORITY_EN
    w_wr_ptr_nxt = r_wr_ptr;
`endif
    s_awvalid = 1'b0;
    s_awaddr  = '0;
    s_awlen   = '0;
    m_awready = '0;
    s_wvalid  = 1'b0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wlast   = 1'b0;
    m_wready  = '0;
    case (r_wr_st)
      W_IDLE: begin
        if (|m_awvalid) begin
          w_wgnt_nxt  = w_wr_pick;
          w_wr_st_nxt = W_ADDR;
        end
      end
      W_ADDR: begin
        s_awvalid         = m_awvalid[r_wgnt];
        s_awaddr          = m_awaddr[r_wgnt*ADDR_WIDTH +: ADDR_WIDTH];
        s_awlen           = m_awlen[r_wgnt*8 +: 8];
        m_awready[r_wgnt] = s_awready;
        if (m_awvalid[r_wgnt] && s_awready) w_wr_st_nxt = W_DATA;
      end
      W_DATA: begin
        s_wvalid         = m_wvalid[r_wgnt];
        s_wdata          = m_wdata[r_wgnt*DATA_WIDTH +: DATA_WIDTH];
        s_wstrb          = m_wstrb[r_wgnt*SW +: SW];
        s_wlast          = m_wlast[r_wgnt];
        m_wready[r_wgnt] = s_wready;
        if (m_wvalid[r_wgnt] && s_wready && m_wlast[r_wgnt]) begin
          w_wr_st_nxt = W_IDLE;
`ifndef IPGEN_MEMORY_ARBITER_FIXED_PRIORITY_EN
          w_wr_ptr_nxt = f_next(r_wgnt);
`endif
        end
      end
      default: w_wr_st_nxt = W_IDLE;
    endcase
  end

  // read path: same shape; read payload only driven while in R_DATA
  always_comb begin
    w_rd_st_nxt = r_rd_st;
    w_rgnt_nxt  = r_rgnt;
`ifndef IPGEN_MEMORY_ARBITER_FIXED_PRIORITY_EN
    w_rd_ptr_nxt = r_rd_ptr;
`endif
    s_arvalid = 1'b0;
    s_araddr  = '0;
    s_arlen   = '0;
    m_arready = '0;
    m_rvalid  = '0;
    m_rdata   = '0;
    m_rlast   = 1'b0;
    s_rready  = 1'b0;
    case (r_rd_st)
      R_IDLE: begin
        if (|m_arvalid) begin
          w_rgnt_nxt  = w_rd_pick;
          w_rd_st_nxt = R_ADDR;
        end
      end
      R_ADDR: begin
        s_arvalid         = m_arvalid[r_rgnt];
        s_araddr          = m_araddr[r_rgnt*ADDR_WIDTH +: ADDR_WIDTH];
        s_arlen           = m_arlen[r_rgnt*8 +: 8];
        m_arready[r_rgnt] = s_arready;
        if (m_arvalid[r_rgnt] && s_arready) w_rd_st_nxt = R_DATA;
      end
      R_DATA: begin
        m_rvalid[r_rgnt] = s_rvalid;
        m_rdata          = s_rdata;
        m_rlast          = s_rlast;
        s_rready         = m_rready[r_rgnt];
        if (s_rvalid && m_rready[r_rgnt] && s_rlast) begin
          w_rd_st_nxt = R_IDLE;
`ifndef IPGEN_MEMORY_ARBITER_FIXED_PRIORITY_EN
          w_rd_ptr_nxt = f_next(r_rgnt);
`endif
        end
      end
      default: w_rd_st_nxt = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ipgen_memory_arbiter.sv
// Self-checking bench for ipgen_memory_arbiter: randomized master/slave agents
// plus a transaction-level reference model compared every cycle.
module tb_ipgen_memory_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic [N-1:0]    m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
  logic [N*AW-1:0] m_awaddr, m_araddr;
  logic [N*8-1:0]  m_awlen, m_arlen;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
  logic [DW-1:0]   m_rdata, s_wdata, s_rdata;
  logic            m_rlast;
  logic            s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
  logic [AW-1:0]   s_awaddr, s_araddr;
  logic [7:0]      s_awlen, s_arlen;
  logic [SW-1:0]   s_wstrb;
  logic            s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic [1:0]      wr_grant, rd_grant;
  logic            wr_busy, rd_busy;

  ipgen_memory_arbiter #(.NUM_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .wr_grant(wr_grant), .rd_grant(rd_grant), .wr_busy(wr_busy), .rd_busy(rd_busy)
  );

  int checks = 0;
  int errors = 0;

  // reference model: owner channel (-1 = idle), address/data phase, pointer
  int mw_own, mw_gnt, mw_ptr, mr_own, mr_gnt, mr_ptr;
  bit mw_dat, mr_dat;
  int mw_own_n, mw_gnt_n, mw_ptr_n, mr_own_n, mr_gnt_n, mr_ptr_n;
  bit mw_dat_n, mr_dat_n;

  // agents and knobs
  int         wrem[N];
  int         srem, rv_delay, stall;
  logic [N-1:0] aw_en, ar_en, rv_ok;
  int         p_req, len_max, p_sawr, p_swr, p_sarr, p_rv, p_mrr, p_wv;
  bit         wr_toggle;
  // pre-edge observations
  logic [N-1:0] hs_aw, hs_w, hs_ar;
  bit           hs_sar, hs_sr;
  logic [7:0]   sar_len;
  int           wbeats, rbeats[N], bad_rvalid;
  int           rd_grants[$];
  bit           prev_raddr;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // arbitration rule from the requester set, expressed as a visiting order
  function automatic int pick(input logic [N-1:0] req, input int ptr);
    int order[$];
`ifdef IPGEN_MEMORY_ARBITER_FIXED_PRIORITY_EN
    for (int k = 0; k < N; k++) order.push_back(k);
`else
    for (int k = 0; k < N; k++) order.push_back((ptr + k) % N);
`endif
    foreach (order[j]) if (req[order[j]]) return order[j];
    return -1;
  endfunction

  function automatic bit pct(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  function automatic bit busy_any();
    bit b;
    b = (mw_own >= 0) || (mr_own >= 0) || (|m_awvalid) || (|m_arvalid) || (|m_wvalid) ||
        s_rvalid || (srem > 0);
    for (int i = 0; i < N; i++) if (wrem[i] > 0) b = 1'b1;
    return b;
  endfunction

  task automatic model_reset();
    mw_own = -1; mw_dat = 0; mw_gnt = 0; mw_ptr = 0;
    mr_own = -1; mr_dat = 0; mr_gnt = 0; mr_ptr = 0;
  endtask

  task automatic clear_inputs();
    m_awvalid = '0; m_awaddr = '0; m_awlen = '0; m_wdata = '0; m_wstrb = '0;
    m_wlast = '0; m_wvalid = '0; m_arvalid = '0; m_araddr = '0; m_arlen = '0;
    m_rready = '0; s_awready = 1'b0; s_wready = 1'b0; s_arready = 1'b0;
    s_rdata = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
    for (int i = 0; i < N; i++) wrem[i] = 0;
    srem = 0; rv_delay = 0;
  endtask

  task automatic rand_inputs();
    m_awvalid = N'($urandom); m_awaddr = {$urandom, $urandom, $urandom, $urandom};
    m_awlen = $urandom; m_wdata = {$urandom, $urandom, $urandom, $urandom};
    m_wstrb = 16'($urandom); m_wlast = N'($urandom); m_wvalid = N'($urandom);
    m_arvalid = N'($urandom); m_araddr = {$urandom, $urandom, $urandom, $urandom};
    m_arlen = $urandom; m_rready = N'($urandom); s_awready = 1'($urandom);
    s_wready = 1'($urandom); s_arready = 1'($urandom); s_rdata = $urandom;
    s_rlast = 1'($urandom); s_rvalid = 1'($urandom);
  endtask

  // compare every output against the model, then note handshakes for the edge
  task automatic sample();
    logic [N-1:0] e_awr, e_wr, e_arr, e_rv;
    logic e_awv, e_wv, e_wl, e_arv, e_rl, e_rr;
    logic [AW-1:0] e_awa, e_ara;
    logic [7:0] e_awl, e_arl;
    logic [DW-1:0] e_wd, e_rd;
    logic [SW-1:0] e_ws;
    int o;
    e_awr = '0; e_wr = '0; e_arr = '0; e_rv = '0;
    e_awv = 0; e_wv = 0; e_wl = 0; e_arv = 0; e_rl = 0; e_rr = 0;
    e_awa = '0; e_ara = '0; e_awl = '0; e_arl = '0; e_wd = '0; e_rd = '0; e_ws = '0;
    o = mw_own;
    if (o >= 0 && !mw_dat) begin
      e_awv = m_awvalid[o]; e_awa = m_awaddr[o*AW +: AW]; e_awl = m_awlen[o*8 +: 8];
      e_awr[o] = s_awready;
    end else if (o >= 0) begin
      e_wv = m_wvalid[o]; e_wd = m_wdata[o*DW +: DW]; e_ws = m_wstrb[o*SW +: SW];
      e_wl = m_wlast[o]; e_wr[o] = s_wready;
    end
    o = mr_own;
    if (o >= 0 && !mr_dat) begin
      e_arv = m_arvalid[o]; e_ara = m_araddr[o*AW +: AW]; e_arl = m_arlen[o*8 +: 8];
      e_arr[o] = s_arready;
    end else if (o >= 0) begin
      e_rv[o] = s_rvalid; e_rd = s_rdata; e_rl = s_rlast; e_rr = m_rready[o];
    end
    chk("s_awvalid", s_awvalid, e_awv);  chk("s_awaddr", s_awaddr, e_awa);
    chk("s_awlen", s_awlen, e_awl);      chk("m_awready", m_awready, e_awr);
    chk("s_wvalid", s_wvalid, e_wv);     chk("s_wdata", s_wdata, e_wd);
    chk("s_wstrb", s_wstrb, e_ws);       chk("s_wlast", s_wlast, e_wl);
    chk("m_wready", m_wready, e_wr);     chk("wr_grant", wr_grant, mw_gnt);
    chk("wr_busy", wr_busy, mw_own >= 0);
    chk("s_arvalid", s_arvalid, e_arv);  chk("s_araddr", s_araddr, e_ara);
    chk("s_arlen", s_arlen, e_arl);      chk("m_arready", m_arready, e_arr);
    chk("m_rvalid", m_rvalid, e_rv);     chk("m_rdata", m_rdata, e_rd);
    chk("m_rlast", m_rlast, e_rl);       chk("s_rready", s_rready, e_rr);
    chk("rd_grant", rd_grant, mr_gnt);   chk("rd_busy", rd_busy, mr_own >= 0);
    // model transitions at the coming edge
    mw_own_n = mw_own; mw_dat_n = mw_dat; mw_gnt_n = mw_gnt; mw_ptr_n = mw_ptr;
    if (mw_own < 0) begin
      if (|m_awvalid) begin mw_own_n = pick(m_awvalid, mw_ptr); mw_gnt_n = mw_own_n; mw_dat_n = 0; end
    end else if (!mw_dat) begin
      if (m_awvalid[mw_own] && s_awready) mw_dat_n = 1;
    end else if (m_wvalid[mw_own] && s_wready && m_wlast[mw_own]) begin
      mw_own_n = -1; mw_dat_n = 0; mw_ptr_n = (mw_own + 1) % N;
    end
    mr_own_n = mr_own; mr_dat_n = mr_dat; mr_gnt_n = mr_gnt; mr_ptr_n = mr_ptr;
    if (mr_own < 0) begin
      if (|m_arvalid) begin mr_own_n = pick(m_arvalid, mr_ptr); mr_gnt_n = mr_own_n; mr_dat_n = 0; end
    end else if (!mr_dat) begin
      if (m_arvalid[mr_own] && s_arready) mr_dat_n = 1;
    end else if (s_rvalid && m_rready[mr_own] && s_rlast) begin
      mr_own_n = -1; mr_dat_n = 0; mr_ptr_n = (mr_own + 1) % N;
    end
    hs_aw = m_awvalid & m_awready; hs_w = m_wvalid & m_wready; hs_ar = m_arvalid & m_arready;
    hs_sar = s_arvalid & s_arready; sar_len = s_arlen; hs_sr = s_rvalid & s_rready;
    if (s_wvalid && s_wready) wbeats++;
    for (int i = 0; i < N; i++) if (m_rvalid[i] && m_rready[i]) rbeats[i]++;
    if ((m_rvalid & ~rv_ok) != '0) bad_rvalid++;
    if (mr_own >= 0 && !mr_dat) begin
      if (!prev_raddr) rd_grants.push_back(int'(rd_grant));
      prev_raddr = 1;
    end else prev_raddr = 0;
  endtask

  // clock edge, then agents react and the model advances
  task automatic advance();
    @(posedge CLK); #1;
    if (!RST) begin model_reset(); return; end
    mw_own = mw_own_n; mw_dat = mw_dat_n; mw_gnt = mw_gnt_n; mw_ptr = mw_ptr_n;
    mr_own = mr_own_n; mr_dat = mr_dat_n; mr_gnt = mr_gnt_n; mr_ptr = mr_ptr_n;
    for (int i = 0; i < N; i++) begin
      if (hs_aw[i]) begin m_awvalid[i] = 0; wrem[i] = int'(m_awlen[i*8 +: 8]) + 1; end
      if (hs_w[i]) begin m_wvalid[i] = 0; wrem[i]--; end
      if (!m_awvalid[i] && wrem[i] == 0 && aw_en[i] && pct(p_req)) begin
        m_awvalid[i] = 1; m_awaddr[i*AW +: AW] = $urandom;
        m_awlen[i*8 +: 8] = 8'($urandom_range(len_max, 0));
      end
      if (wrem[i] > 0 && !m_wvalid[i] && pct(p_wv)) begin
        m_wvalid[i] = 1; m_wdata[i*DW +: DW] = $urandom;
        m_wstrb[i*SW +: SW] = SW'($urandom); m_wlast[i] = (wrem[i] == 1);
      end
      if (hs_ar[i]) m_arvalid[i] = 0;
      if (!m_arvalid[i] && ar_en[i] && pct(p_req)) begin
        m_arvalid[i] = 1; m_araddr[i*AW +: AW] = $urandom;
        m_arlen[i*8 +: 8] = 8'($urandom_range(len_max, 0));
      end
      m_rready[i] = pct(p_mrr);
    end
    if (hs_sr) begin s_rvalid = 0; srem--; end
    if (hs_sar) begin srem = int'(sar_len) + 1; rv_delay = stall; end
    if (srem > 0 && !s_rvalid) begin
      if (rv_delay > 0) rv_delay--;
      else if (pct(p_rv)) begin s_rvalid = 1; s_rdata = $urandom; s_rlast = (srem == 1); end
    end
    s_awready = pct(p_sawr);
    s_arready = pct(p_sarr);
    s_wready  = wr_toggle ? ~s_wready : pct(p_swr);
  endtask

  task automatic cyc();
    @(negedge CLK); sample(); advance();
  endtask

  task automatic issue_aw(input int ch, input logic [AW-1:0] a, input logic [7:0] l);
    m_awvalid[ch] = 1; m_awaddr[ch*AW +: AW] = a; m_awlen[ch*8 +: 8] = l;
  endtask

  task automatic issue_ar(input int ch, input logic [AW-1:0] a, input logic [7:0] l);
    m_arvalid[ch] = 1; m_araddr[ch*AW +: AW] = a; m_arlen[ch*8 +: 8] = l;
  endtask

  task automatic defaults();
    aw_en = '0; ar_en = '0; rv_ok = '1; p_req = 100; len_max = 0;
    p_sawr = 100; p_swr = 100; p_sarr = 100; p_rv = 100; p_mrr = 100; p_wv = 100;
    stall = 0; wr_toggle = 0;
  endtask

  task automatic drain(input string tag, input int maxc);
    int n;
    defaults();
    n = 0;
    while (busy_any() && n < maxc) begin cyc(); n++; end
    chk(tag, n >= maxc, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base, rbase, n;
    int exp_g[4];
    defaults(); model_reset(); clear_inputs();
    wbeats = 0; bad_rvalid = 0; prev_raddr = 0; hs_aw = '0; hs_w = '0; hs_ar = '0;
    hs_sar = 0; hs_sr = 0; sar_len = '0;
    for (int i = 0; i < N; i++) rbeats[i] = 0;

    // reset held with random inputs: every output must be 0
    for (int k = 0; k < 6; k++) begin rand_inputs(); cyc(); end
    clear_inputs();
    RST = 1'b1;
    for (int k = 0; k < 3; k++) cyc();
    chk("rst_wr_busy", wr_busy, 1'b0);
    chk("rst_rd_busy", rd_busy, 1'b0);

    // single write on ch2: address appears one cycle after the request
    base = wbeats;
    issue_aw(2, 32'h100, 8'd3);
    cyc();
    @(negedge CLK); sample();
    chk("sw_awvalid", s_awvalid, 1'b1);
    chk("sw_awaddr", s_awaddr, 32'h100);
    chk("sw_awlen", s_awlen, 8'd3);
    chk("sw_grant", wr_grant, 2'd2);
    advance();
    drain("sw_timeout", 30);
    chk("sw_beats", wbeats - base, 4);
    chk("sw_idle", wr_busy, 1'b0);

    // continuous reads from ch0, ch1, ch3
    rd_grants.delete();
    ar_en = 4'b1011;
    n = 0;
    while (rd_grants.size() < 4 && n < 80) begin cyc(); n++; end
    chk("rr_timeout", n >= 80, 1'b0);
`ifdef IPGEN_MEMORY_ARBITER_FIXED_PRIORITY_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 3, 0};
`endif
    for (int k = 0; k < 4; k++)
      chk($sformatf("rr_grant%0d", k), (rd_grants.size() > k) ? rd_grants[k] : -1, exp_g[k]);
    drain("rr_drain", 60);

    // backpressure: s_wready toggles through an 8-beat burst on ch1
    base = wbeats;
    wr_toggle = 1; s_wready = 1;
    issue_aw(1, 32'h300, 8'd7);
    n = 0;
    while (busy_any() && n < 60) begin cyc(); n++; end
    chk("bp_timeout", n >= 60, 1'b0);
    chk("bp_beats", wbeats - base, 8);
    wr_toggle = 0;

    // randomized mixed traffic on all channels
    base = wbeats;
    aw_en = '1; ar_en = '1; p_req = 30; len_max = 3;
    p_sawr = 70; p_swr = 70; p_sarr = 70; p_rv = 70; p_mrr = 70; p_wv = 70;
    repeat (500) cyc();
    drain("rand_drain", 300);
    chk("rand_traffic", wbeats > base, 1'b1);

    // concurrency: ch1 writes while ch3 reads with a 5-cycle rvalid stall
    base = wbeats; rbase = rbeats[3]; bad_rvalid = 0;
    rv_ok = 4'b1000; stall = 5;
    issue_aw(1, 32'h500, 8'd3);
    issue_ar(3, 32'h600, 8'd3);
    n = 0;
    while ((mw_own >= 0 || m_awvalid[1] || wrem[1] > 0) && n < 30) begin cyc(); n++; end
    chk("cc_wr_timeout", n >= 30, 1'b0);
    chk("cc_wr_beats", wbeats - base, 4);
    chk("cc_rd_busy", rd_busy, 1'b1);
    n = 0;
    while (busy_any() && n < 40) begin cyc(); n++; end
    chk("cc_rd_timeout", n >= 40, 1'b0);
    chk("cc_rd_beats", rbeats[3] - rbase, 4);
    chk("cc_bad_rvalid", bad_rvalid, 0);
    defaults();

    // reset in the middle of beat 2 of a 4-beat write
    base = wbeats;
    issue_aw(2, 32'h200, 8'd3);
    n = 0;
    while (wbeats - base < 1 && n < 20) begin cyc(); n++; end
    chk("mr_timeout", n >= 20, 1'b0);
    chk("mr_in_burst", wr_busy, 1'b1);
    RST = 1'b0;
    model_reset();
    #1;
    sample();
    chk("mr_wr_busy", wr_busy, 1'b0);
    chk("mr_s_wvalid", s_wvalid, 1'b0);
    chk("mr_m_wready", m_wready, '0);
    clear_inputs();
    cyc();
    RST = 1'b1;
    issue_aw(0, 32'h40, 8'd1);
    issue_aw(3, 32'h80, 8'd1);
    cyc();
    @(negedge CLK); sample();
    chk("mr_regrant", wr_grant, 2'd0);
    chk("mr_awaddr", s_awaddr, 32'h40);
    advance();
    drain("mr_drain", 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ipgen_memory_arbiter.md
# ipgen_memory_arbiter

N-channel arbiter that merges `NUM_CH` burst memory-mapped master ports into one slave-side memory port of the same protocol. It has independent write and read paths. Each path grants one channel at a time, by round-robin or fixed priority, and holds the grant until the last data beat of that burst completes. It sits between several user-logic masters and a single system memory interface.

## Interface
Parameters:
- `NUM_CH`, 4, number of upstream master channels, 2..16
- `ADDR_WIDTH`, 32, address width, up to 32
- `DATA_WIDTH`, 32, data width: 8, 16, 32, 64, 128, 256 or 512
- `GW`: derived, `$clog2(NUM_CH)`, grant index width

Ports. Channel i of a packed `m_*` bus occupies `[i*W +: W]`.
- `CLK`  in  1  clock; all logic is rising-edge.
- `RST`  in  1  asynchronous, active-low reset.
- `m_awvalid` / `m_awready`  in / out  NUM_CH / NUM_CH  per-channel write-address handshake.
- `m_awaddr`, `m_awlen`  in  NUM_CH*ADDR_WIDTH, NUM_CH*8  per-channel write address and burst length (beats-1).
- `m_wdata`, `m_wstrb`, `m_wlast`  in  NUM_CH*DATA_WIDTH, NUM_CH*DATA_WIDTH/8, NUM_CH  per-channel write beat.
- `m_wvalid` / `m_wready`  in / out  NUM_CH / NUM_CH  per-channel write-data handshake.
- `m_arvalid` / `m_arready`  in / out  NUM_CH / NUM_CH  per-channel read-address handshake.
- `m_araddr`, `m_arlen`  in  NUM_CH*ADDR_WIDTH, NUM_CH*8  per-channel read address and length.
- `m_rdata`, `m_rlast`  out  DATA_WIDTH, 1  read beat, broadcast to all channels.
- `m_rvalid` / `m_rready`  out / in  NUM_CH / NUM_CH  per-channel read-data handshake.
- `s_awvalid`, `s_awaddr`, `s_awlen` / `s_awready`  out / in  1, ADDR_WIDTH, 8 / 1  downstream write address.
- `s_wdata`, `s_wstrb`, `s_wlast`, `s_wvalid` / `s_wready`  out / in  DATA_WIDTH, DATA_WIDTH/8, 1, 1 / 1  downstream write data.
- `s_arvalid`, `s_araddr`, `s_arlen` / `s_arready`  out / in  1, ADDR_WIDTH, 8 / 1  downstream read address.
- `s_rdata`, `s_rlast`, `s_rvalid` / `s_rready`  in / out  DATA_WIDTH, 1, 1 / 1  downstream read data.
- `wr_grant`, `rd_grant`  out  GW each  registered index of the channel currently granted on each path.
- `wr_busy`, `rd_busy`  out  1 each  asserted while the path is not IDLE.

## Operation
- The write FSM has three states: `W_IDLE`, `W_ADDR` and `W_DATA`. The read FSM mirrors it with `R_IDLE`, `R_ADDR` and `R_DATA`. The two FSMs are fully independent.
- **IDLE:** if any `m_awvalid` is high, the FSM registers the winner into `wr_grant` and moves to `W_ADDR`. While in IDLE, no `m_*ready` is asserted.
- **W_ADDR:**
  - `s_awvalid = m_awvalid[g]`.
  - `s_awaddr` and `s_awlen` are muxed from channel g.
  - `m_awready[g] = s_awready`.
  - On the `s_awvalid & s_awready` handshake, the FSM moves to `W_DATA`.
- **W_DATA:**
  - `s_w*` carries channel g.
  - `m_wready[g] = s_wready`.
  - On a handshake with `s_wlast` high, the FSM returns to `W_IDLE` and sets the round-robin pointer to (g+1) mod NUM_CH.
- **Read path:**
  - `s_ar*` is handled the same way in `R_ADDR`.
  - In `R_DATA`: `m_rvalid[g] = s_rvalid` and `s_rready = m_rready[g]`.
  - On the `s_rlast` handshake, the FSM returns to `R_IDLE` and advances `rd_ptr`.
- **Round-robin selection:** the grant goes to the first requesting channel at index ≥ ptr, wrapping to 0. The write and read paths keep separate pointers.
- **Outside the granted channel and state:** all `m_*ready` and `m_rvalid` bits are 0. All `s_*valid` outputs are 0, and the `s_*` payload outputs are driven to 0.
- **Burst termination:** the burst ends only on `wlast`/`rlast`, never on a beat count. `awlen` = 0 is a single-beat burst.
- **Early write data:** write data from a master that is not granted, or that is not yet in `W_DATA`, is stalled (wready = 0).
- **Master obligations:** a master must hold valid and payload stable until ready.

## Timing
- Reset (RST = 0, asynchronous):
  - Both FSMs go to IDLE and both pointers are cleared to 0.
  - `wr_grant` = `rd_grant` = 0 and `wr_busy` = `rd_busy` = 0.
  - Every valid, ready and payload output is 0.
- Reset asserted mid-burst aborts the burst immediately. No recovery state is kept.
- Arbitration costs one cycle: a request seen in IDLE at edge n produces `s_awvalid`/`s_arvalid` from cycle n+1.
- All other paths are combinational pass-through with zero added latency.
- Turnaround: the cycle after the last beat is IDLE, so the next grant's address appears 2 cycles after the last beat.
- Requests that arrive while the path is busy wait. Arbitration is evaluated only in IDLE.
- A write and a read can each be in progress at the same time, from the same or different channels.

## Configuration
- `IPGEN_MEMORY_ARBITER_FIXED_PRIORITY_EN`:
  - **Defined:** fixed priority; the lowest requesting index always wins and the pointers are unused.
  - **Undefined (default):** round-robin as described under Operation.

## Test plan
- **Reset values:** hold RST = 0 with all inputs randomized → every output is 0. Release RST with no requests → both `*_busy` stay 0.
- **Single write:** ch2 issues awaddr = 0x100, awlen = 3 with 4 beats → `s_awvalid` rises 1 cycle later with `s_awaddr` = 0x100 and `wr_grant` = 2. All 4 beats are forwarded and the path is IDLE after `wlast`.
- **Round-robin:** ch0, ch1 and ch3 request reads continuously → grants go 0, 1, 3, 0. With the macro defined → 0, 0, 0.
- **Backpressure:** `s_wready` toggles every cycle during an 8-beat burst → `m_wready[g]` mirrors it and no beat is lost or duplicated. Non-granted `m_wready` stays 0.
- **Concurrency:** ch1 writes while ch3 reads, and `s_rvalid` stalls for 5 cycles → the write completes unaffected and `m_rvalid[3]` is the only active rvalid.
- **Reset mid-burst:** RST = 0 during beat 2 of a 4-beat write → all outputs are 0 within the same cycle. After release, a new ch0 request is granted normally with the pointer at 0.
